mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multi-cycle control unit for the next-generation MIPS core. It replaces the combinational single-cycle main decoder with a registered finite state machine. The FSM sequences fetch, decode, execute, memory and write-back over several cycles and waits on a memory ready handshake. It also counts retired instructions. It sits between the instruction register (opcode/funct fields) and the datapath muxes, register-file and memory write enables, and ALU.

## Interface
Parameters:
- ALUOP_W, 3, width of aluop; codes: add 0, sub 1, or 2, slt 3, and 4, "use funct" 7; upper bits zero when ALUOP_W>3
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- op_c  in  6  opcode field of instruction register
- funct  in  6  funct field of instruction register
- zero  in  1  ALU zero flag (branch compare)
- mem_ready  in  1  memory completes current access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write access (valid with mem_req)
- iord  out  1  0: address = PC, 1: address = ALU result register
- ir_we  out  1  load instruction register
- pc_we  out  1  load PC
- pc_src  out  2  0: ALU, 1: branch target reg, 2: jump target, 3: rs (JR)
- alu_src_a  out  1  0: PC, 1: rs
- alu_src_b  out  2  0: rt, 1: const 4, 2: extended imm, 3: extended imm<<2
- aluop  out  ALUOP_W  ALU operation
- ext_c  out  1  1: LUI (imm<<16), 0: sign extend
- reg_we  out  1  register-file write enable
- dest_reg_c  out  2  0: rd, 1: rt, 2: r31
- result_c  out  2  0: ALU, 1: memory data, 2: PC (link), 3: shifter
- sh_d_c  out  1  shift direction, 1: left (SLL), 0: right (SRL)
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction
- retired  out  CNT_W  retired-instruction count
- trap  out  1  illegal-opcode flag (see Configuration)

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, IMMEX, IMMWB, BRANCH, JUMP, TRAP.
- Each output not listed for a state is 0 in that state.
- FETCH: mem_req=1, iord=0, alu_src_b=1, aluop=add.
  - Hold while mem_ready=0.
  - When mem_ready=1: ir_we=1, pc_we=1, pc_src=0; next state DECODE.
- DECODE: alu_src_b=3, aluop=add (branch target computed).
  - Opcode 100011 (LW) or 101011 (SW) -> MEMADR.
  - Opcode 000000 with funct 001000 (JR) -> JUMP.
  - Opcode 000000, other funct -> EXEC.
  - Opcode 001000/001100/001101/001010/001111 -> IMMEX.
  - Opcode 000100/000101 -> BRANCH.
  - Opcode 000010/000011 -> JUMP.
  - Any other opcode -> FETCH (NOP, retired) or TRAP.
- MEMADR: alu_src_a=1, alu_src_b=2, aluop=add; next MEMRD (LW) or MEMWR (SW).
- MEMRD: mem_req=1, iord=1; hold until mem_ready=1, then -> MEMWB.
- MEMWR: mem_req=1, mem_we=1, iord=1; hold until mem_ready=1, then instr_done, -> FETCH.
- MEMWB: reg_we=1, dest_reg_c=1, result_c=1, instr_done; -> FETCH.
- EXEC: alu_src_a=1, aluop=7; -> ALUWB.
- ALUWB: reg_we=1, dest_reg_c=0, instr_done; -> FETCH.
  - result_c=3 for funct 000000 (SLL, sh_d_c=1) or 000010 (SRL, sh_d_c=0); otherwise result_c=0.
- IMMEX: alu_src_a=1, alu_src_b=2, ext_c=1 only for LUI; -> IMMWB.
  - aluop: ADDI/LUI=add, ORI=or, SLTI=slt, ANDI=and.
- IMMWB: reg_we=1, dest_reg_c=1, result_c=0, instr_done; -> FETCH.
- BRANCH: alu_src_a=1, aluop=sub, pc_src=1, instr_done; -> FETCH.
  - pc_we = zero for BEQ, ~zero for BNE.
- JUMP: pc_we=1, instr_done; -> FETCH.
  - J: pc_src=2.
  - JAL: pc_src=2, reg_we=1, dest_reg_c=2, result_c=2.
  - JR: pc_src=3.
- op_c and funct are sampled in every state after DECODE (the instruction register is stable).
- retired increments by 1 on every instr_done cycle and wraps from 2^CNT_W-1 to 0.

## Timing
- Reset (async assert, any state): state=FETCH, retired=0, trap=0. All other outputs are the FETCH decode, i.e. mem_req=1, alu_src_b=1, rest 0.
- Reset released mid-access: the memory transaction is abandoned; fetch restarts from the current PC.
- Minimum latency with mem_ready always 1:
  - R-type, immediate: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - Branch, J/JAL/JR: 3 cycles.
- Each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds one cycle.
- mem_ready is ignored outside those states.
- Outputs are a combinational decode of the registered state plus op_c/funct/zero.
- The next state registers on the rising clk edge.

## Configuration
- MC_CTRL_TRAP_EN defined: an illegal opcode in DECODE -> TRAP.
  - TRAP sets trap=1 with all enables 0 and holds until reset. No instr_done, retired not incremented.
- MC_CTRL_TRAP_EN undefined: an illegal opcode retires as NOP.
  - instr_done pulses in DECODE, next state FETCH; trap is tied 0; TRAP state absent.

## Test plan
- Reset with mem_ready=1 -> mem_req=1, retired=0, trap=0. After release, ADD (op 000000, funct 100000) -> reg_we=1, dest_reg_c=0 in the 4th cycle; retired=1.
- LW (100011) with mem_ready held 0 for 3 cycles in MEMRD -> 8 cycles total; MEMWB has reg_we=1, result_c=1, dest_reg_c=1.
- BEQ (000100) zero=1 -> pc_we=1, pc_src=1 in cycle 3. BNE (000101) zero=1 -> pc_we=0; both give instr_done.
- JAL (000011) -> cycle 3: pc_src=2, reg_we=1, dest_reg_c=2, result_c=2. JR (funct 001000) -> pc_src=3, reg_we=0.
- SLL/SRL (funct 000000/000010) -> ALUWB has result_c=3 with sh_d_c=1 and 0 respectively. ORI -> aluop=2; LUI -> ext_c=1.
- Opcode 111111: with MC_CTRL_TRAP_EN -> trap=1 sticky, retired unchanged; without -> instr_done in DECODE, retired+1. CNT_W=4 run of 17 instructions -> retired=1.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: fetch/decode/execute/memory/write-back sequencing and a retired-instruction counter.
// Optional illegal-opcode trap state is enabled by defining MC_CTRL_TRAP_EN; otherwise illegal opcodes retire as NOP.
module mc_ctrl #(
    parameter int unsigned ALUOP_W = 3,
    parameter int unsigned CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         op_c,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               iord,
    output logic               ir_we,
    output logic               pc_we,
    output logic [1:0]         pc_src,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] aluop,
    output logic               ext_c,
    output logic               reg_we,
    output logic [1:0]         dest_reg_c,
    output logic [1:0]         result_c,
    output logic               sh_d_c,
    output logic               instr_done,
    output logic [CNT_W-1:0]   retired,
    output logic               trap
);

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXEC,
        ALUWB,
        IMMEX,
        IMMWB,
        BRANCH,
        JUMP
`ifdef MC_CTRL_TRAP_EN
        , TRAP
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(3'd0);
    localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(3'd1);
    localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(3'd2);
    localparam logic [ALUOP_W-1:0] ALU_SLT   = ALUOP_W'(3'd3);
    localparam logic [ALUOP_W-1:0] ALU_AND   = ALUOP_W'(3'd4);
    localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(3'd7);

    state_t state, state_nxt;

    logic is_mem, is_r, is_jr, is_imm, is_br, is_j;

    always_comb begin
        is_mem = (op_c == OP_LW) || (op_c == OP_SW);
        is_r   = (op_c == OP_RTYPE);
        is_jr  = is_r && (funct == FN_JR);
        is_imm = (op_c == OP_ADDI) || (op_c == OP_ANDI) || (op_c == OP_ORI) ||
                 (op_c == OP_SLTI) || (op_c == OP_LUI);
        is_br  = (op_c == OP_BEQ) || (op_c == OP_BNE);
        is_j   = (op_c == OP_J) || (op_c == OP_JAL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 2'd0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        aluop      = ALU_ADD;
        ext_c      = 1'b0;
        reg_we     = 1'b0;
        dest_reg_c = 2'd0;
        result_c   = 2'd0;
        sh_d_c     = 1'b0;
        instr_done = 1'b0;
        trap       = 1'b0;

        case (state)
            FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'd1;
                if (mem_ready) begin
                    // Write enables are masked while reset is held so the
                    // reset-time outputs show only the plain fetch request.
                    ir_we     = rst_n;
                    pc_we     = rst_n;
                    state_nxt = DECODE;
                end
            end
            DECODE: begin
                alu_src_b = 2'd3;
                if (is_mem) begin
                    state_nxt = MEMADR;
                end else if (is_r) begin
                    state_nxt = is_jr ? JUMP : EXEC;
                end else if (is_imm) begin
                    state_nxt = IMMEX;
                end else if (is_br) begin
                    state_nxt = BRANCH;
                end else if (is_j) begin
                    state_nxt = JUMP;
                end else begin
`ifdef MC_CTRL_TRAP_EN
                    state_nxt = TRAP;
`else
                    instr_done = 1'b1;
                    state_nxt  = FETCH;
`endif
                end
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                state_nxt = (op_c == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    state_nxt = MEMWB;
                end
            end
            MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_nxt  = FETCH;
                end
            end
            MEMWB: begin
                reg_we     = 1'b1;
                dest_reg_c = 2'd1;
                result_c   = 2'd1;
                instr_done = 1'b1;
                state_nxt  = FETCH;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                aluop     = ALU_FUNCT;
                state_nxt = ALUWB;
            end
            ALUWB: begin
                reg_we     = 1'b1;
                instr_done = 1'b1;
                state_nxt  = FETCH;
                if (funct == FN_SLL) begin
                    result_c = 2'd3;
                    sh_d_c   = 1'b1;
                end else if (funct == FN_SRL) begin
                    result_c = 2'd3;
                end
            end
            IMMEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                ext_c     = (op_c == OP_LUI);
                state_nxt = IMMWB;
                case (op_c)
                    OP_ORI:  aluop = ALU_OR;
                    OP_SLTI: aluop = ALU_SLT;
                    OP_ANDI: aluop = ALU_AND;
                    default: aluop = ALU_ADD;
                endcase
            end
            IMMWB: begin
                reg_we     = 1'b1;
                dest_reg_c = 2'd1;
                instr_done = 1'b1;
                state_nxt  = FETCH;
            end
            BRANCH: begin
                alu_src_a  = 1'b1;
                aluop      = ALU_SUB;
                pc_src     = 2'd1;
                pc_we      = (op_c == OP_BEQ) ? zero : ~zero;
                instr_done = 1'b1;
                state_nxt  = FETCH;
            end
            JUMP: begin
                pc_we      = 1'b1;
                instr_done = 1'b1;
                state_nxt  = FETCH;
                if (is_jr) begin
                    pc_src = 2'd3;
                end else begin
                    pc_src = 2'd2;
                end
                if (op_c == OP_JAL) begin
                    reg_we     = 1'b1;
                    dest_reg_c = 2'd2;
                    result_c   = 2'd2;
                end
            end
`ifdef MC_CTRL_TRAP_EN
            TRAP: begin
                trap      = 1'b1;
                state_nxt = TRAP;
            end
`endif
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired <= '0;
        end else if (instr_done) begin
            retired <= retired + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: random instruction stream with a latency/output reference model; a monitor checks each retirement.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op_c, funct;
    logic       zero, mem_ready;

    logic        mem_req, mem_we, iord, ir_we, pc_we, alu_src_a, ext_c, reg_we, sh_d_c, instr_done, trap;
    logic [1:0]  pc_src, alu_src_b, dest_reg_c, result_c;
    logic [2:0]  aluop;
    logic [31:0] retired;

    logic        mem_req4, mem_we4, iord4, ir_we4, pc_we4, alu_src_a4, ext_c4, reg_we4, sh_d_c4, instr_done4, trap4;
    logic [1:0]  pc_src4, alu_src_b4, dest_reg_c4, result_c4;
    logic [2:0]  aluop4;
    logic [3:0]  retired4;

    mc_ctrl #(.ALUOP_W(3), .CNT_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .op_c(op_c), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .aluop(aluop), .ext_c(ext_c), .reg_we(reg_we),
        .dest_reg_c(dest_reg_c), .result_c(result_c), .sh_d_c(sh_d_c), .instr_done(instr_done),
        .retired(retired), .trap(trap)
    );

    mc_ctrl #(.ALUOP_W(3), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .op_c(op_c), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req4), .mem_we(mem_we4), .iord(iord4), .ir_we(ir_we4), .pc_we(pc_we4), .pc_src(pc_src4),
        .alu_src_a(alu_src_a4), .alu_src_b(alu_src_b4), .aluop(aluop4), .ext_c(ext_c4), .reg_we(reg_we4),
        .dest_reg_c(dest_reg_c4), .result_c(result_c4), .sh_d_c(sh_d_c4), .instr_done(instr_done4),
        .retired(retired4), .trap(trap4)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req, mem_we, iord, ir_we, pc_we;
        logic [1:0] pc_src;
        logic       alu_a;
        logic [1:0] alu_b;
        logic [2:0] aluop;
        logic       ext, reg_we;
        logic [1:0] dest, result;
        logic       sh, trp;
    } ov_t;

    typedef struct {
        ov_t         fin;
        ov_t         prev;
        int          lat;
        int unsigned ret;
    } exp_t;

    typedef enum {C_R, C_JR, C_IMM, C_LW, C_SW, C_BR, C_J, C_JAL, C_ILL} cls_t;

    ov_t cur, cur4, prev_v, rst_exp, trap_exp;
    assign cur  = {mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_a, alu_src_b, aluop,
                   ext_c, reg_we, dest_reg_c, result_c, sh_d_c, trap};
    assign cur4 = {mem_req4, mem_we4, iord4, ir_we4, pc_we4, pc_src4, alu_src_a4, alu_src_b4, aluop4,
                   ext_c4, reg_we4, dest_reg_c4, result_c4, sh_d_c4, trap4};

    exp_t        sb[$];
    exp_t        e;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int unsigned issued = 0;

    logic [5:0] ops [0:13] = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2b, 6'h08, 6'h0c,
                               6'h0d, 6'h0a, 6'h0f, 6'h04, 6'h05, 6'h02, 6'h03};
    logic [5:0] bad_ops [0:4] = '{6'h3f, 6'h01, 6'h20, 6'h3e, 6'h11};
    logic [5:0] r_fns [0:7] = '{6'h20, 6'h22, 6'h25, 6'h2a, 6'h24, 6'h00, 6'h02, 6'h08};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic cls_t classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00:                         return (fn == 6'h08) ? C_JR : C_R;
            6'h23:                         return C_LW;
            6'h2b:                         return C_SW;
            6'h08, 6'h0c, 6'h0d, 6'h0a, 6'h0f: return C_IMM;
            6'h04, 6'h05:                  return C_BR;
            6'h02:                         return C_J;
            6'h03:                         return C_JAL;
            default:                       return C_ILL;
        endcase
    endfunction

    // Outputs expected in the cycle that pulses instr_done.
    function automatic ov_t exp_fin(input logic [5:0] op, input logic [5:0] fn, input logic z);
        ov_t v = '0;
        case (classify(op, fn))
            C_R: begin
                v.reg_we = 1'b1;
                if (fn == 6'h00) begin v.result = 2'd3; v.sh = 1'b1; end
                else if (fn == 6'h02) v.result = 2'd3;
            end
            C_IMM: begin v.reg_we = 1'b1; v.dest = 2'd1; end
            C_LW:  begin v.reg_we = 1'b1; v.dest = 2'd1; v.result = 2'd1; end
            C_SW:  begin v.mem_req = 1'b1; v.mem_we = 1'b1; v.iord = 1'b1; end
            C_BR:  begin v.alu_a = 1'b1; v.aluop = 3'd1; v.pc_src = 2'd1; v.pc_we = (op == 6'h04) ? z : ~z; end
            C_J:   begin v.pc_we = 1'b1; v.pc_src = 2'd2; end
            C_JAL: begin v.pc_we = 1'b1; v.pc_src = 2'd2; v.reg_we = 1'b1; v.dest = 2'd2; v.result = 2'd2; end
            C_JR:  begin v.pc_we = 1'b1; v.pc_src = 2'd3; end
            default: v.alu_b = 2'd3;
        endcase
        return v;
    endfunction

    // Outputs expected in the cycle just before instr_done.
    function automatic ov_t exp_prev(input logic [5:0] op, input logic [5:0] fn, input int nm);
        ov_t v = '0;
        case (classify(op, fn))
            C_R:   begin v.alu_a = 1'b1; v.aluop = 3'd7; end
            C_IMM: begin
                v.alu_a = 1'b1; v.alu_b = 2'd2; v.ext = (op == 6'h0f);
                v.aluop = (op == 6'h0d) ? 3'd2 : (op == 6'h0a) ? 3'd3 : (op == 6'h0c) ? 3'd4 : 3'd0;
            end
            C_LW:  begin v.mem_req = 1'b1; v.iord = 1'b1; end
            C_SW:  if (nm > 0) begin v.mem_req = 1'b1; v.mem_we = 1'b1; v.iord = 1'b1; end
                   else begin v.alu_a = 1'b1; v.alu_b = 2'd2; end
            C_ILL: begin v.mem_req = 1'b1; v.ir_we = 1'b1; v.pc_we = 1'b1; v.alu_b = 2'd1; end
            default: v.alu_b = 2'd3;
        endcase
        return v;
    endfunction

    task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic z, input int nf, input int nm);
        bit   mr[$];
        exp_t x;
        cls_t c = classify(op, fn);
        for (int i = 0; i < nf; i++) mr.push_back(1'b0);
        mr.push_back(1'b1);
        mr.push_back(1'($urandom));
        case (c)
            C_R, C_IMM: begin mr.push_back(1'($urandom)); mr.push_back(1'($urandom)); end
            C_LW: begin
                mr.push_back(1'($urandom));
                for (int i = 0; i < nm; i++) mr.push_back(1'b0);
                mr.push_back(1'b1);
                mr.push_back(1'($urandom));
            end
            C_SW: begin
                mr.push_back(1'($urandom));
                for (int i = 0; i < nm; i++) mr.push_back(1'b0);
                mr.push_back(1'b1);
            end
            C_ILL: ;
            default: mr.push_back(1'($urandom));
        endcase
        x.fin  = exp_fin(op, fn, z);
        x.prev = exp_prev(op, fn, nm);
        x.lat  = mr.size();
        x.ret  = issued;
        issued++;
        sb.push_back(x);
        for (int i = 0; i < mr.size(); i++) begin
            op_c      = (i <= nf) ? 6'($urandom) : op;
            funct     = (i <= nf) ? 6'($urandom) : fn;
            zero      = z;
            mem_ready = mr[i];
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue_rand();
        logic [5:0] op, fn;
        int         nf, nm;
        op = ops[$urandom_range(0, 13)];
`ifndef MC_CTRL_TRAP_EN
        if ($urandom_range(0, 9) == 0) op = bad_ops[$urandom_range(0, 4)];
`endif
        fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : r_fns[$urandom_range(0, 7)];
        nf = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        nm = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
        issue(op, fn, 1'($urandom), nf, nm);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            cyc = 0;
        end else begin
            cyc++;
            if (instr_done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: instr_done=1, expected no retirement at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    chk("latency", 64'(cyc), 64'(e.lat));
                    chk("final_outputs", 64'(cur), 64'(e.fin));
                    chk("prev_outputs", 64'(prev_v), 64'(e.prev));
                    chk("retired", 64'(retired), 64'(e.ret));
                    chk("retired_w4", 64'(retired4), 64'(e.ret & 32'hf));
                    chk("final_outputs_w4", 64'(cur4), 64'(e.fin));
                    chk("done_w4", 64'(instr_done4), 64'd1);
                end
                cyc = 0;
            end else if (cyc > 40) begin
                checks++;
                errors++;
                $display("FAIL done_timeout: waited %0d cycles, expected instr_done at %0t", cyc, $time);
                cyc = 0;
            end
        end
        prev_v = cur;
    end

    initial begin
        op_c      = '0;
        funct     = '0;
        zero      = 1'b0;
        mem_ready = 1'b1;
        rst_exp   = '0;
        rst_exp.mem_req = 1'b1;
        rst_exp.alu_b   = 2'd1;
        trap_exp  = '0;
        trap_exp.trp = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 64'(cur), 64'(rst_exp));
        chk("reset_outputs_w4", 64'(cur4), 64'(rst_exp));
        chk("reset_retired", 64'(retired), 64'd0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        issued = 0;

        issue(6'h00, 6'h20, 1'b0, 0, 0);
        issue(6'h23, 6'h00, 1'b0, 0, 3);
        issue(6'h04, 6'h00, 1'b1, 0, 0);
        issue(6'h05, 6'h00, 1'b1, 0, 0);
        issue(6'h03, 6'h00, 1'b0, 0, 0);
        issue(6'h00, 6'h08, 1'b0, 0, 0);
        issue(6'h00, 6'h00, 1'b0, 0, 0);
        issue(6'h00, 6'h02, 1'b0, 1, 0);
        issue(6'h0d, 6'h00, 1'b0, 0, 0);
        issue(6'h0f, 6'h00, 1'b0, 0, 0);
        issue(6'h2b, 6'h00, 1'b0, 2, 2);
`ifndef MC_CTRL_TRAP_EN
        issue(6'h3f, 6'h15, 1'b0, 0, 0);
`endif
        for (int n = 0; n < 60; n++) issue_rand();

        // Abandon a load mid-access with reset
        mem_ready = 1'b1;
        op_c      = 6'h23;
        funct     = 6'h00;
        repeat (3) begin @(posedge clk); #1; end
        mem_ready = 1'b0;
        @(posedge clk);
        #2;
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("midreset_outputs", 64'(cur), 64'(rst_exp));
        chk("midreset_retired", 64'(retired), 64'd0);
        chk("midreset_retired_w4", 64'(retired4), 64'd0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        issued = 0;
        for (int n = 0; n < 20; n++) issue_rand();

`ifdef MC_CTRL_TRAP_EN
        mem_ready = 1'b1;
        op_c      = 6'h3f;
        funct     = 6'h00;
        repeat (2) begin @(posedge clk); #1; end
        for (int n = 0; n < 4; n++) begin
            mem_ready = 1'($urandom);
            @(negedge clk);
            chk("trap_outputs", 64'(cur), 64'(trap_exp));
            chk("trap_retired", 64'(retired), 64'(issued));
            chk("trap_done", 64'(instr_done), 64'd0);
            @(posedge clk);
            #1;
        end
`endif
        mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        chk("final_retired", 64'(retired), 64'(issued));
        chk("final_retired_w4", 64'(retired4), 64'(issued & 32'hf));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
